// File: rtl/rsa_two_power_mod_arbiter.sv
// rtl/rsa_two_power_mod_arbiter.sv - round-robin sharing of one two-power-mod engine among NUM_REQ requesters
module rsa_two_power_mod_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MOD_WIDTH = 256,
  parameter int INT_WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*INT_WIDTH-1:0]   req_power,
  input  logic [NUM_REQ*MOD_WIDTH-1:0]   req_modulus,
  output logic [NUM_REQ-1:0]             rsp_valid,
  input  logic [NUM_REQ-1:0]             rsp_ready,
  output logic [MOD_WIDTH-1:0]           rsp_result,
  output logic                           eng_i_valid,
  input  logic                           eng_i_ready,
  output logic [INT_WIDTH-1:0]           eng_i_power,
  output logic [MOD_WIDTH-1:0]           eng_i_modulus,
  input  logic                           eng_o_valid,
  output logic                           eng_o_ready,
  input  logic [MOD_WIDTH-1:0]           eng_o_result,
  output logic                           busy,
  output logic [15:0]                    done_count
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t               state, state_nxt;
  logic [PW-1:0]        ptr, grant, win;
  logic                 win_found;
  logic [PW:0]          scan_idx;
  logic [INT_WIDTH-1:0] sel_power, power_q;
  logic [MOD_WIDTH-1:0] sel_modulus, modulus_q, result_q;
  logic                 rsp_done;

  // First valid requester in scan order ptr, ptr+1, ... wraps modulo NUM_REQ
  always_comb begin
    win       = ptr;
    win_found = 1'b0;
    scan_idx  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_idx = {1'b0, ptr} + (PW+1)'(i);
      if (scan_idx >= (PW+1)'(NUM_REQ))
        scan_idx = scan_idx - (PW+1)'(NUM_REQ);
      if (!win_found && req_valid[scan_idx[PW-1:0]]) begin
        win       = scan_idx[PW-1:0];
        win_found = 1'b1;
      end
    end
  end

  always_comb begin
    sel_power   = '0;
    sel_modulus = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win == PW'(k)) begin
        sel_power   = req_power[k*INT_WIDTH +: INT_WIDTH];
        sel_modulus = req_modulus[k*MOD_WIDTH +: MOD_WIDTH];
      end
    end
  end

  assign rsp_done = rsp_ready[grant];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_found)   state_nxt = ISSUE;
      ISSUE:   if (eng_i_ready) state_nxt = WAIT;
      WAIT:    if (eng_o_valid) state_nxt = RESP;
      RESP:    if (rsp_done)    state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  // req_ready is gated by rst so every handshake output reads 0 while reset is held
  always_comb begin
    req_ready   = '0;
    rsp_valid   = '0;
    eng_i_valid = 1'b0;
    eng_o_ready = 1'b0;
    busy        = (state != IDLE);
    case (state)
      IDLE:    if (win_found && !rst) req_ready[win] = 1'b1;
      ISSUE:   eng_i_valid = 1'b1;
      WAIT:    eng_o_ready = 1'b1;
      RESP:    rsp_valid[grant] = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr        <= '0;
      grant      <= '0;
      power_q    <= '0;
      modulus_q  <= '0;
      result_q   <= '0;
      done_count <= '0;
    end else begin
      if (state == IDLE && win_found) begin
        grant     <= win;
        power_q   <= sel_power;
        modulus_q <= sel_modulus;
      end
      if (state == WAIT && eng_o_valid)
        result_q <= eng_o_result;
      if (state == RESP && rsp_done) begin
        ptr        <= (grant == PW'(NUM_REQ-1)) ? '0 : grant + 1'b1;
        done_count <= done_count + 16'd1;
      end
    end
  end

  assign eng_i_power   = power_q;
  assign eng_i_modulus = modulus_q;
  assign rsp_result    = result_q;

endmodule

// File: tb/tb_rsa_two_power_mod_arbiter.sv
// tb/tb_rsa_two_power_mod_arbiter.sv - directed bench; the bench plays the engine and all requesters
module tb_rsa_two_power_mod_arbiter;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    req_valid, req_ready, rsp_valid, rsp_ready;
  logic [127:0]  req_power;
  logic [1023:0] req_modulus;
  logic [255:0]  rsp_result, eng_i_modulus, eng_o_result;
  logic [31:0]   eng_i_power;
  logic          eng_i_valid, eng_i_ready, eng_o_valid, eng_o_ready, busy;
  logic [15:0]   done_count;
  int            n_assert = 0;
  int            n_fail = 0;

  always #5 clk = ~clk;

  rsa_two_power_mod_arbiter #(.NUM_REQ(4), .MOD_WIDTH(256), .INT_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_power(req_power), .req_modulus(req_modulus),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .eng_i_valid(eng_i_valid), .eng_i_ready(eng_i_ready),
    .eng_i_power(eng_i_power), .eng_i_modulus(eng_i_modulus),
    .eng_o_valid(eng_o_valid), .eng_o_ready(eng_o_ready), .eng_o_result(eng_o_result),
    .busy(busy), .done_count(done_count)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] pow2mod(input logic [31:0] p, input logic [255:0] m);
    logic [255:0] r;
    r = 256'd1 % m;
    for (int i = 0; i < int'(p); i++) r = (r * 2) % m;
    return r;
  endfunction

  // One full transaction from an IDLE negedge to the IDLE negedge after the response handshake
  task automatic txn(input string tag, input logic [3:0] vld, input int k, input logic [31:0] p,
                     input logic [255:0] m, input logic [255:0] exp_res, input int istall, input int rhold);
    logic [3:0] oh;
    oh = 4'b0001 << k;
    req_power[k*32 +: 32]    = p;
    req_modulus[k*256 +: 256] = m;
    req_valid = vld;
    #1;
    chk({tag, "_req_ready"}, req_ready, oh);
    @(negedge clk); #1;
    req_power[k*32 +: 32] = ~p;
    #1;
    chk({tag, "_eng_i_valid"}, eng_i_valid, 1);
    chk({tag, "_eng_i_power"}, eng_i_power, p);
    chk({tag, "_eng_i_modulus"}, eng_i_modulus, m);
    chk({tag, "_issue_req_ready"}, req_ready, 0);
    chk({tag, "_issue_busy"}, busy, 1);
    for (int s = 0; s < istall; s++) begin
      @(negedge clk); #1;
      chk({tag, "_stall_eng_i_valid"}, eng_i_valid, 1);
      chk({tag, "_stall_power"}, eng_i_power, p);
      chk({tag, "_stall_eng_o_ready"}, eng_o_ready, 0);
    end
    eng_i_ready = 1'b1;
    @(negedge clk);
    eng_i_ready = 1'b0;
    #1;
    chk({tag, "_wait_eng_o_ready"}, eng_o_ready, 1);
    chk({tag, "_wait_eng_i_valid"}, eng_i_valid, 0);
    eng_o_valid  = 1'b1;
    eng_o_result = pow2mod(p, m);
    @(negedge clk);
    eng_o_valid  = 1'b0;
    eng_o_result = '0;
    #1;
    chk({tag, "_rsp_valid"}, rsp_valid, oh);
    chk({tag, "_rsp_result"}, rsp_result, exp_res);
    chk({tag, "_resp_eng_o_ready"}, eng_o_ready, 0);
    rsp_ready = ~oh;
    for (int h = 0; h < rhold; h++) begin
      @(negedge clk); #1;
      chk({tag, "_hold_rsp_valid"}, rsp_valid, oh);
      chk({tag, "_hold_rsp_result"}, rsp_result, exp_res);
      chk({tag, "_hold_req_ready"}, req_ready, 0);
      chk({tag, "_hold_eng_i_valid"}, eng_i_valid, 0);
      chk({tag, "_hold_busy"}, busy, 1);
    end
    rsp_ready = oh;
    @(negedge clk);
    rsp_ready = '0;
    #1;
    chk({tag, "_idle_busy"}, busy, 0);
    chk({tag, "_idle_rsp_valid"}, rsp_valid, 0);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0; req_power = '0; req_modulus = '0; rsp_ready = '0;
    eng_i_ready = 1'b0; eng_o_valid = 1'b0; eng_o_result = '0;
    @(negedge clk); #1;
    chk("rst_busy", busy, 0);
    chk("rst_done_count", done_count, 0);
    chk("rst_eng_i_valid", eng_i_valid, 0);
    chk("rst_rsp_result", rsp_result, 0);
    @(negedge clk);
    rst = 1'b0;

    txn("single_r2", 4'b0100, 2, 32'd4, 256'd13, 256'd3, 0, 0);
    chk("single_done_count", done_count, 1);

    req_valid = '0;
    eng_o_valid = 1'b1;
    eng_o_result = 256'hdead;
    #1;
    chk("idle_eng_o_ready", eng_o_ready, 0);
    @(negedge clk); #1;
    chk("idle_eng_o_ignored_busy", busy, 0);
    chk("idle_eng_o_ignored_rsp", rsp_valid, 0);
    eng_o_valid = 1'b0;
    eng_o_result = '0;

    req_valid = 4'b1100;
    #1;
    chk("ptr_after_r2", req_ready, 4'b1000);
    txn("r0_pow0_stall", 4'b0001, 0, 32'd0, 256'd97, 256'd1, 5, 0);
    chk("r0_done_count", done_count, 2);

    txn("hold_r1", 4'b1111, 1, 32'd3, 256'd7, 256'd1, 0, 10);
    txn("after_hold_r2", 4'b1111, 2, 32'd10, 256'd1000, 256'd24, 0, 0);
    chk("after_hold_done_count", done_count, 4);

    req_valid = 4'b0001;
    req_power[31:0] = 32'd1;
    req_modulus[255:0] = 256'd5;
    #1;
    chk("rstw_req_ready", req_ready, 4'b0001);
    @(negedge clk);
    eng_i_ready = 1'b1;
    @(negedge clk);
    eng_i_ready = 1'b0;
    #1;
    chk("rstw_in_wait", eng_o_ready, 1);
    rst = 1'b1;
    #1;
    chk("rstw_eng_o_ready", eng_o_ready, 0);
    chk("rstw_busy", busy, 0);
    chk("rstw_done_count", done_count, 0);
    chk("rstw_eng_i_modulus", eng_i_modulus, 0);
    chk("rstw_req_ready_held", req_ready, 0);
    chk("rstw_rsp_valid", rsp_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    req_valid = '0;

    for (int k = 0; k < 4; k++) req_power[k*32 +: 32] = 32'd5;
    req_modulus[0*256 +: 256] = 256'd11;
    req_modulus[1*256 +: 256] = 256'd13;
    req_modulus[2*256 +: 256] = 256'd17;
    req_modulus[3*256 +: 256] = 256'd19;
    txn("rot0", 4'b1111, 0, 32'd5, 256'd11, 256'd10, 0, 0);
    txn("rot1", 4'b1111, 1, 32'd5, 256'd13, 256'd6, 0, 0);
    txn("rot2", 4'b1111, 2, 32'd5, 256'd17, 256'd15, 0, 0);
    txn("rot3", 4'b1111, 3, 32'd5, 256'd19, 256'd13, 0, 0);
    chk("rot_wrap_grant0", req_ready, 4'b0001);
    chk("rot_done_count", done_count, 4);
    req_valid = '0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/rsa_two_power_mod_arbiter.md
# rsa_two_power_mod_arbiter

Round-robin arbiter that shares one two-power-mod engine (computes 2^power mod modulus) between NUM_REQ independent requesters. The block sits between the RSA key-setup clients (Montgomery constant generators, one per channel) and the single engine instance. It runs the engine one transaction at a time and routes each result back to the requester that issued it. The block contains no arithmetic; it only sequences and routes.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- MOD_WIDTH, 256, modulus/result width
- INT_WIDTH, 32, power width

Ports:
- clk  in  1  single clock; all logic posedge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high
- req_power  in  NUM_REQ*INT_WIDTH  flattened; slice k = requester k
- req_modulus  in  NUM_REQ*MOD_WIDTH  flattened; slice k = requester k
- rsp_valid  out  NUM_REQ  result valid for requester k; at most one bit high
- rsp_ready  in  NUM_REQ  per-requester result accept
- rsp_result  out  MOD_WIDTH  shared result bus, meaningful when any rsp_valid is high
- eng_i_valid / eng_i_ready  out / in  1  engine input handshake
- eng_i_power  out  INT_WIDTH  latched power
- eng_i_modulus  out  MOD_WIDTH  latched modulus
- eng_o_valid / eng_o_ready  in / out  1  engine output handshake
- eng_o_result  in  MOD_WIDTH  engine result
- busy  out  1  high in any state other than IDLE
- done_count  out  16  completed transactions, wraps 0xFFFF->0

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Winner g = first k with req_valid[k], scanning ptr, ptr+1, ... mod NUM_REQ.
  - req_ready[g] is driven combinationally in the same cycle. The handshake completes that cycle.
  - On the handshake: latch slice g of power and modulus, latch grant=g, go to ISSUE.
  - No req_valid: stay in IDLE.
- ISSUE: eng_i_valid=1 with the latched operands. When eng_i_ready is high, go to WAIT.
- WAIT: eng_o_ready=1. When eng_o_valid is high, latch eng_o_result into the result register and go to RESP.
- RESP:
  - rsp_valid[grant]=1; rsp_result = result register.
  - When rsp_ready[grant] is high: ptr <= (grant+1) mod NUM_REQ, done_count++, go to IDLE.
- req_ready is all-zero outside IDLE. eng_i_valid is high only in ISSUE. eng_o_ready is high only in WAIT. rsp_valid is nonzero only in RESP.
- Operands and grant are stable from the IDLE handshake until the return to IDLE. The requester may change its inputs after its handshake.
- eng_o_valid outside WAIT is ignored; eng_o_ready stays 0, so the engine holds its output.
- rsp_ready bits for non-granted requesters are ignored.

## Timing
- Reset (rst high, any state, asynchronous):
  - state=IDLE, ptr=0, grant=0, done_count=0.
  - Result and operand registers = 0.
  - All handshake outputs = 0; busy=0.
  - The engine shares rst, so an in-flight transaction is dropped with no response.
- Request accepted at cycle T:
  - eng_i_valid rises at T+1.
  - Engine accept at T+1+a, where a ≥ 0 cycles of eng_i_ready stall.
  - rsp_valid rises the cycle after the eng_o_valid/eng_o_ready handshake.
- Back-to-back: a new request can be accepted in the cycle after the rsp handshake (one IDLE cycle minimum between transactions).
- A request that drops req_valid before being granted is not recorded. Pending requests carry no state in the arbiter.
- All NUM_REQ requesting continuously gives strict rotation 0,1,...,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 transactions.
- ptr wraps from NUM_REQ-1 to 0.
- rsp_ready held low: rsp_valid and rsp_result stay stable, busy stays 1, no new grant.

## Test plan
- Single request, requester 2, power=4, modulus=13 -> req_ready[2] the same cycle; eng_i_valid the next cycle with power=4, modulus=13; rsp_valid[2] with rsp_result=3; done_count=1; ptr=3.
- Requester 0, power=0, modulus=97 -> rsp_result=1; no other rsp_valid bit ever high.
- All four requesters valid from reset, distinct moduli (11, 13, 17, 19), power=5 -> grants in order 0,1,2,3; results 10, 6, 15, 13 routed to the matching rsp_valid bits; then requester 0 is granted again.
- Hold rsp_ready[1] low 10 cycles in RESP with other requesters valid -> rsp_result stable, req_ready all-zero, no eng_i_valid; the grant proceeds one cycle after rsp_ready[1] rises.
- Assert rst in WAIT -> all outputs 0 asynchronously; after release a new request completes correctly and done_count restarts from 0.
- Stall eng_i_ready low 5 cycles in ISSUE, and drive eng_o_valid high in IDLE -> eng_i_valid and operands held stable; eng_o_ready stays 0 outside WAIT.
